// File: rtl/fetch_unit.sv
// PC / fetch stage: drives the instruction-memory address, latches the instruction into IR and
// offers it to decode with valid/ready; resolves the next PC. Optional macro: FETCH_HALT_ON_ZERO_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    input  logic [31:0] instr_in,
    output logic [31:0] instr_out,
    output logic [31:0] ir_pc_out,
    output logic [31:0] pc_plus4_out,
    output logic        valid_out,
    input  logic        ready_in,
    input  logic        branch_en,
    input  logic        zero_in,
    input  logic        jump_en,
    output logic        halted_out,
    output logic        fault_out,
    output logic [31:0] instr_count
);

    localparam int unsigned PC_W     = 32;
    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_WORDS);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t            state;
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   ir;
    logic [PC_W-1:0]   ir_pc;
    logic [PC_W-1:0]   count;
    logic              fault;

    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   branch_off;
    logic [PC_W-1:0]   next_pc;
    logic              accept;

    // Next-PC selection for the instruction currently in IR; jump has priority over branch
    always_comb begin
        pc_plus4   = ir_pc + 32'd4;
        branch_off = {{14{ir[15]}}, ir[15:0], 2'b00};
        accept     = (state == ISSUE) && ready_in;
        next_pc    = pc_plus4;
        if (jump_en) begin
            next_pc = {pc_plus4[31:28], ir[25:0], 2'b00};
        end else if (branch_en && zero_in) begin
            next_pc = pc_plus4 + branch_off;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= FETCH;
            pc    <= RESET_PC;
            ir    <= '0;
            ir_pc <= RESET_PC;
            count <= '0;
            fault <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (pc >= PC_LIMIT) begin
                        fault <= 1'b1;
                        state <= HALT;
                    end
`ifdef FETCH_HALT_ON_ZERO_EN
                    // An all-zero word marks the end of the program
                    else if (instr_in == 32'h0000_0000) begin
                        state <= HALT;
                    end
`endif
                    else begin
                        ir    <= instr_in;
                        ir_pc <= pc;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (accept) begin
                        count <= count + 32'd1;
                        pc    <= next_pc;
                        state <= FETCH;
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

    assign pc_out       = pc;
    assign instr_out    = ir;
    assign ir_pc_out    = ir_pc;
    assign pc_plus4_out = pc_plus4;
    assign valid_out    = (state == ISSUE);
    assign halted_out   = (state == HALT);
    assign fault_out    = fault;
    assign instr_count  = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a small program exercising jump, branch, stall, fault and reset.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic [31:0] instr_out;
    logic [31:0] ir_pc_out;
    logic [31:0] pc_plus4_out;
    logic        valid_out;
    logic        ready_in;
    logic        branch_en;
    logic        zero_in;
    logic        jump_en;
    logic        halted_out;
    logic        fault_out;
    logic [31:0] instr_count;

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .pc_out       (pc_out),
        .instr_in     (instr_in),
        .instr_out    (instr_out),
        .ir_pc_out    (ir_pc_out),
        .pc_plus4_out (pc_plus4_out),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .branch_en    (branch_en),
        .zero_in      (zero_in),
        .jump_en      (jump_en),
        .halted_out   (halted_out),
        .fault_out    (fault_out),
        .instr_count  (instr_count)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [1024];
    assign instr_in = (pc_out < 32'h1000) ? mem[pc_out[11:2]] : 32'hDEAD_BEEF;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errs    = 0;
    logic [31:0] count_exp = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted instruction must match the oldest scoreboard entry
    always @(negedge clk) begin
        if (!reset && valid_out && ready_in) begin
            if (sb.size() == 0) begin
                vectors++;
                errs++;
                $display("FAIL unexpected_accept: got instr %h at %h, expected none", instr_out, ir_pc_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("acc_instr", instr_out, e.instr);
                chk("acc_ir_pc", ir_pc_out, e.pc);
                chk("acc_pc_plus4", pc_plus4_out, e.pc + 32'd4);
            end
        end
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (valid_out) begin
                ok = 1'b1;
                return;
            end
            @(posedge clk); #1;
        end
        vectors++;
        errs++;
        $display("FAIL wait_valid: got no valid_out within 10 cycles, expected valid_out=1");
    endtask

    // Issue one instruction: optional stall with junk flags, then accept with the given flags
    task automatic do_issue(input logic [31:0] e_instr, input logic [31:0] e_pc,
                            input logic j, input logic b, input logic z,
                            input int stall, input logic [31:0] e_next);
        bit ok;
        wait_valid(ok);
        if (!ok) return;
        sb.push_back('{instr: e_instr, pc: e_pc});
        for (int i = 0; i < stall; i++) begin
            ready_in = 1'b0; jump_en = 1'b1; branch_en = 1'b1; zero_in = 1'b1;
            @(posedge clk); #1;
            chk("stall_valid", 32'(valid_out), 32'd1);
            chk("stall_instr", instr_out, e_instr);
            chk("stall_pc", pc_out, e_pc);
            chk("stall_count", instr_count, count_exp);
        end
        ready_in = 1'b1; jump_en = j; branch_en = b; zero_in = z;
        @(posedge clk); #1;
        ready_in = 1'b0; jump_en = 1'b0; branch_en = 1'b0; zero_in = 1'b0;
        count_exp = count_exp + 32'd1;
        chk("next_pc", pc_out, e_next);
        chk("post_accept_valid", 32'(valid_out), 32'd0);
        chk("post_accept_count", instr_count, count_exp);
    endtask

    task automatic chk_reset_values();
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_ir_pc", ir_pc_out, 32'h0);
        chk("rst_pc_plus4", pc_plus4_out, 32'h4);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_halted", 32'(halted_out), 32'd0);
        chk("rst_fault", 32'(fault_out), 32'd0);
        chk("rst_count", instr_count, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h2108_0001;
        mem[0]  = 32'h0022_1824;
        mem[1]  = 32'h0800_000A;
        mem[10] = 32'h0800_0014;
        mem[11] = 32'h0000_0000;
        mem[12] = 32'h0800_0400;
        mem[20] = 32'h1003_FFEB;
        mem[21] = 32'h0800_000B;

        reset = 1'b1; ready_in = 1'b0; jump_en = 1'b0; branch_en = 1'b0; zero_in = 1'b0;
        #1;
        chk_reset_values();
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("first_valid", 32'(valid_out), 32'd1);

        do_issue(32'h0022_1824, 32'h00, 1'b0, 1'b0, 1'b0, 0, 32'h04);
        do_issue(32'h0800_000A, 32'h04, 1'b1, 1'b0, 1'b0, 0, 32'h28);
        do_issue(32'h0800_0014, 32'h28, 1'b1, 1'b1, 1'b1, 0, 32'h50);
        do_issue(32'h1003_FFEB, 32'h50, 1'b0, 1'b1, 1'b1, 0, 32'h00);
        do_issue(32'h0022_1824, 32'h00, 1'b0, 1'b0, 1'b0, 5, 32'h04);
        do_issue(32'h0800_000A, 32'h04, 1'b1, 1'b0, 1'b0, 0, 32'h28);
        do_issue(32'h0800_0014, 32'h28, 1'b1, 1'b0, 1'b0, 0, 32'h50);
        do_issue(32'h1003_FFEB, 32'h50, 1'b0, 1'b1, 1'b0, 0, 32'h54);
        do_issue(32'h0800_000B, 32'h54, 1'b1, 1'b0, 1'b0, 0, 32'h2C);
`ifdef FETCH_HALT_ON_ZERO_EN
        @(posedge clk); #1;
        chk("zero_halted", 32'(halted_out), 32'd1);
        chk("zero_fault", 32'(fault_out), 32'd0);
        chk("zero_valid", 32'(valid_out), 32'd0);
        chk("zero_count", instr_count, 32'd9);
        repeat (3) @(posedge clk); #1;
        chk("halt_pc_frozen", pc_out, 32'h2C);
        chk("halt_count_frozen", instr_count, 32'd9);
`else
        do_issue(32'h0000_0000, 32'h2C, 1'b0, 1'b0, 1'b0, 0, 32'h30);
        do_issue(32'h0800_0400, 32'h30, 1'b1, 1'b0, 1'b0, 0, 32'h1000);
        @(posedge clk); #1;
        chk("fault_fault", 32'(fault_out), 32'd1);
        chk("fault_halted", 32'(halted_out), 32'd1);
        chk("fault_valid", 32'(valid_out), 32'd0);
        ready_in = 1'b1;
        repeat (3) @(posedge clk); #1;
        ready_in = 1'b0;
        chk("halt_pc_frozen", pc_out, 32'h1000);
        chk("halt_count_frozen", instr_count, 32'd11);
        chk("halt_instr_frozen", instr_out, 32'h0800_0400);
        chk("halt_valid", 32'(valid_out), 32'd0);
`endif

        // Asynchronous reset from HALT
        reset = 1'b1;
        #1;
        chk_reset_values();
        count_exp = 32'd0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("restart_valid", 32'(valid_out), 32'd1);
        do_issue(32'h0022_1824, 32'h00, 1'b0, 1'b0, 1'b0, 0, 32'h04);

        // Reset while an accept is pending: the accept must be lost
        begin
            bit ok;
            wait_valid(ok);
            ready_in = 1'b1;
            reset    = 1'b1;
            #1;
            chk("midissue_valid", 32'(valid_out), 32'd0);
            @(posedge clk); #1;
            chk("midissue_count", instr_count, 32'd0);
            chk("midissue_pc", pc_out, 32'h0);
            reset    = 1'b0;
            ready_in = 1'b0;
            count_exp = 32'd0;
        end
        do_issue(32'h0022_1824, 32'h00, 1'b0, 1'b0, 1'b0, 0, 32'h04);

        @(posedge clk); #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and fetch stage of the single-cycle MIPS datapath. Drives the word-addressed instruction memory's byte read address, latches the returned instruction into an instruction register (IR), and presents it to decode/control with a valid/ready handshake. Next-PC selection (sequential, BEQ target, J target) is resolved here from control/ALU flags returned for the issued instruction. Also reports halt/fault status and a retired-instruction count.

## Interface
- RESET_PC, 32'h0000_0000, byte address fetched first after reset
- IMEM_WORDS, 1024, instruction memory depth in words; valid byte addresses are 0 .. 4*IMEM_WORDS-4
- clk  input  1  rising-edge clock
- reset  input  1  reset, asynchronous, active-high
- pc_out  output  32  byte read address to instruction memory
- instr_in  input  32  combinational instruction-memory read data for pc_out
- instr_out  output  32  IR contents, the issued instruction
- ir_pc_out  output  32  byte address of the instruction in IR
- pc_plus4_out  output  32  ir_pc_out + 4 (combinational)
- valid_out  output  1  IR holds an instruction offered to decode
- ready_in  input  1  decode accepts the offered instruction
- branch_en  input  1  control: issued instruction is BEQ
- zero_in  input  1  ALU zero flag for the issued instruction
- jump_en  input  1  control: issued instruction is J
- halted_out  output  1  fetch stopped
- fault_out  output  1  stop was caused by an address fault
- instr_count  output  32  instructions accepted since reset

## Operation
- FSM states: FETCH, ISSUE, HALT.
- FETCH: pc_out = pc. At clock edge: IR <= instr_in, ir_pc <= pc; -> ISSUE. If pc >= 4*IMEM_WORDS: no capture, fault_out <= 1, -> HALT.
- ISSUE: valid_out = 1. Hold IR, pc, and state while ready_in = 0. On valid_out & ready_in (accept): instr_count += 1 (wraps at 2^32), pc <= next_pc, -> FETCH.
- next_pc (evaluated only on accept, all 32-bit, carries discarded):
  - jump_en = 1: {pc_plus4[31:28], IR[25:0], 2'b00}
  - else branch_en & zero_in: pc_plus4 + ({{14{IR[15]}}, IR[15:0], 2'b00})
  - else: pc_plus4
  - jump_en and branch_en both high: jump wins.
- Branch/jump flags are ignored outside an accept cycle.
- Range check happens in FETCH on the new pc, so an out-of-range jump/branch target or sequential run past the last word faults one cycle after accept.
- HALT: absorbing; valid_out = 0, pc/IR/instr_count frozen; left only by reset.
- Reset (any time, including mid-ISSUE with ready_in high): immediately state = FETCH, pc = RESET_PC, IR = 0, ir_pc = RESET_PC, instr_count = 0, halted_out = 0, fault_out = 0. A pending accept in that cycle is lost.

## Timing
- Reset values: pc_out = RESET_PC, instr_out = 0, ir_pc_out = RESET_PC, pc_plus4_out = RESET_PC+4, valid_out = 0, halted_out = 0, fault_out = 0, instr_count = 0.
- First edge after reset deassertion: capture; valid_out high from the following cycle.
- Throughput: 2 cycles per instruction with ready_in held high (FETCH, ISSUE).
- valid_out, halted_out, fault_out, instr_out, ir_pc_out, instr_count are registered/state-decoded; pc_plus4_out is combinational from ir_pc.
- halted_out asserts the cycle after the edge that enters HALT.
- valid_out never drops without an accept except by reset.

## Configuration
- FETCH_HALT_ON_ZERO_EN defined: in FETCH, instr_in == 32'h0000_0000 is treated as end of program: no capture, -> HALT with halted_out = 1, fault_out = 0, instr_count unchanged.
- Undefined: all-zero word is captured and issued as a normal instruction (sll $0,$0,0 nop).

## Test plan
- Reset then ready_in = 1, memory word 0 = 32'h0022_1824: valid_out at cycle 2 with instr_out = 32'h0022_1824, ir_pc_out = 0, pc_plus4_out = 4; pc_out = 4 after accept; instr_count = 1.
- ready_in held low for 5 ISSUE cycles: IR, pc_out, instr_count stable, valid_out stays 1; accept on cycle 6 gives instr_count += 1 exactly once.
- Word 10 = 32'h0800_0014 accepted with jump_en = 1 and branch_en = 1 -> pc_out = 32'h50 next FETCH.
- Word 20 = 32'h1003_FFEB, branch_en = 1: zero_in = 1 -> pc_out = 0; zero_in = 0 -> pc_out = 32'h54.
- Jump target word 1023+1 (pc = 32'h1000): fault_out = 1, halted_out = 1, valid_out = 0; assert reset mid-HALT -> all outputs return to reset values and fetch restarts at RESET_PC.
- Zero word at address 32'h2C: with FETCH_HALT_ON_ZERO_EN, halted_out = 1, fault_out = 0; without, issued with instr_out = 0 and pc_out advances to 32'h30.
